// File: rtl/seq_steps_pkg.sv
// seq_pkg: mode encodings, LFSR seed/taps and the shared LFSR step function
package seq_pkg;
  localparam logic [1:0] SEQ_FWD = 2'd0;
  localparam logic [1:0] SEQ_BWD = 2'd1;
  localparam logic [1:0] SEQ_PING = 2'd2;
  localparam logic [1:0] SEQ_RAND = 2'd3;
  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // taps 16,14,13,11 as bit positions 15,13,12,10
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction
endpackage

// File: rtl/seq_steps_if.sv
// seq_steps_if: control, level-write and output bundle of the step sequencer
interface seq_steps_if #(parameter int BITS = 16, parameter int STEPS = 8, parameter int LEN_BITS = 24);
  localparam int SW = $clog2(STEPS);
  logic run;
  logic sync;
  logic [1:0] mode;
  logic [SW-1:0] last_step;
  logic [LEN_BITS-1:0] len;
  logic wr_en;
  logic [SW-1:0] wr_addr;
  logic signed [BITS-1:0] wr_data;
  logic signed [BITS-1:0] sig_out;
  logic [SW-1:0] step_idx;
  logic step_tick;
  modport master(output run, sync, mode, last_step, len, wr_en, wr_addr, wr_data,
                 input sig_out, step_idx, step_tick);
  modport slave(input run, sync, mode, last_step, len, wr_en, wr_addr, wr_data,
                output sig_out, step_idx, step_tick);
endinterface

// File: rtl/seq_steps_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR, steps only when enabled, reset to seed
module lfsr16 import seq_pkg::*; (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_en,
  output logic [15:0] o_state
);
  logic [15:0] r_state;
  always_ff @(posedge clk)
    if (!rst_n) r_state <= LFSR_SEED;
    else if (i_en) r_state <= lfsr_next(r_state);
  assign o_state = r_state;
endmodule

// File: rtl/seq_steps.sv
// seq_steps: programmable signed level step sequencer (fwd/bwd/ping-pong/random)
module seq_steps import seq_pkg::*; #(
  parameter int BITS = 16,
  parameter int STEPS = 8,
  parameter int LEN_BITS = 24
) (
  input logic clk,
  input logic rst_n,
  seq_steps_if.slave bus
);
  localparam int SW = $clog2(STEPS);
  logic signed [BITS-1:0] r_lvl [STEPS];
  logic [LEN_BITS-1:0] r_cnt;
  logic [SW-1:0] r_step;
  logic r_dir_dn;
  logic signed [BITS-1:0] r_out;
  logic r_tick;
  logic w_adv, w_lfsr_en, w_dir_nx;
  logic [15:0] w_lfsr, w_lfsr_nx;
  logic [SW-1:0] w_l, w_cand, w_next;
  assign w_l = bus.last_step;
  // sync cancels an advance falling on the same edge
  assign w_adv = bus.run && r_cnt >= bus.len && !bus.sync;
  assign w_lfsr_en = w_adv && bus.mode == SEQ_RAND;
  assign w_lfsr_nx = lfsr_next(w_lfsr);
  assign w_cand = w_lfsr_nx[SW-1:0];
  lfsr16 u_lfsr (.clk(clk), .rst_n(rst_n), .i_en(w_lfsr_en), .o_state(w_lfsr));
  always_comb begin
    w_next = r_step;
    w_dir_nx = r_dir_dn;
    case (bus.mode)
      SEQ_FWD: w_next = (r_step >= w_l) ? '0 : r_step + 1'b1;
      SEQ_BWD: w_next = (r_step == '0 || r_step > w_l) ? w_l : r_step - 1'b1;
      SEQ_PING:
        if (!r_dir_dn) begin
          w_next = (r_step >= w_l) ? ((w_l == '0) ? '0 : w_l - 1'b1) : r_step + 1'b1;
          w_dir_nx = r_step >= w_l && w_l != '0;
        end else begin
          w_next = (r_step == '0) ? ((w_l == '0) ? '0 : SW'(1)) : r_step - 1'b1;
          w_dir_nx = r_step != '0;
        end
      default: w_next = (w_cand <= w_l) ? w_cand : w_cand & w_l;
    endcase
  end
  always_ff @(posedge clk)
    if (!rst_n) begin
      r_cnt <= '0;
      r_step <= '0;
      r_dir_dn <= 1'b0;
      r_out <= '0;
      r_tick <= 1'b0;
      for (int i = 0; i < STEPS; i++) r_lvl[i] <= '0;
    end else begin
      if (bus.wr_en) r_lvl[bus.wr_addr] <= bus.wr_data;
      if (bus.run) r_out <= r_lvl[r_step];
      r_tick <= w_adv;
      if (bus.sync) begin
        r_cnt <= '0;
        r_step <= (bus.mode == SEQ_BWD) ? w_l : '0;
        r_dir_dn <= 1'b0;
      end else if (bus.run) begin
        r_cnt <= w_adv ? '0 : r_cnt + 1'b1;
        if (w_adv) begin
          r_step <= w_next;
          r_dir_dn <= w_dir_nx;
        end
      end
    end
  assign bus.sig_out = r_out;
  assign bus.step_idx = r_step;
  assign bus.step_tick = r_tick;
endmodule
